// File: rtl/ann_output_classifier.sv
// Output-layer classifier: snapshots ANN node values on start, scans for the
// argmax, applies a confidence threshold and drives the class/7-seg outputs.
//
// state | meaning
// IDLE  | waiting for start (accepted only when valid is low)
// SCAN  | comparing one snapshot element per cycle
// DONE  | register digit/reject/seven_seg and raise valid
module ann_output_classifier #(
  parameter int                         NUM_OUTPUTS = 16,
  parameter int                         DATA_W      = 16,
  parameter logic signed [DATA_W-1:0]   THRESHOLD   = '0
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] node_vals [NUM_OUTPUTS],
  output logic                     busy,
  output logic                     valid,
  output logic [3:0]               digit,
  output logic                     reject,
  output logic [7:0]               seven_seg
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_OUTPUTS - 1);

  state_t                   state, state_nxt;
  logic signed [DATA_W-1:0] snap [NUM_OUTPUTS];
  logic [3:0]               idx;
  logic [3:0]               best_idx;
  logic signed [DATA_W-1:0] best_val;
  logic                     accept;
  logic                     is_rej;

  function automatic logic [7:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_seg = 8'h3F;
      4'h1: hex_seg = 8'h06;
      4'h2: hex_seg = 8'h5B;
      4'h3: hex_seg = 8'h4F;
      4'h4: hex_seg = 8'h66;
      4'h5: hex_seg = 8'h6D;
      4'h6: hex_seg = 8'h7D;
      4'h7: hex_seg = 8'h07;
      4'h8: hex_seg = 8'h7F;
      4'h9: hex_seg = 8'h6F;
      4'hA: hex_seg = 8'h77;
      4'hB: hex_seg = 8'h7C;
      4'hC: hex_seg = 8'h39;
      4'hD: hex_seg = 8'h5E;
      4'hE: hex_seg = 8'h79;
      default: hex_seg = 8'h71;
    endcase
  endfunction

  // The valid cycle is spent in IDLE, so it must still block a new start.
  assign accept = (state == IDLE) && start && !valid;
  assign is_rej = (best_val < THRESHOLD);
  assign busy   = (state != IDLE) || valid;

  always_ff @(posedge clk) begin
    if (n_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      snap      <= '{default: '0};
      idx       <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      valid     <= 1'b0;
      digit     <= '0;
      reject    <= 1'b0;
      seven_seg <= 8'h00;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            snap <= node_vals;
            idx  <= '0;
          end
        end
        SCAN: begin
          if (idx == 4'd0) begin
            best_val <= snap[idx];
            best_idx <= '0;
          end else if (snap[idx] > best_val) begin
            best_val <= snap[idx];
            best_idx <= idx;
          end
          // Explicit terminal test; idx never relies on 4-bit wrap.
          if (idx != LAST_IDX) idx <= idx + 4'd1;
        end
        DONE: begin
          digit     <= best_idx;
          reject    <= is_rej;
          seven_seg <= is_rej ? 8'h40 : hex_seg(best_idx);
          valid     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ann_output_classifier.sv
// Self-checking bench for ann_output_classifier: directed cases plus random
// vectors compared against a max-then-first-index reference model.
module tb_ann_output_classifier;

  logic               clk;
  logic               n_rst;
  logic               start;
  logic signed [15:0] node_vals [16];
  logic               busy, valid, reject;
  logic [3:0]         digit;
  logic [7:0]         seven_seg;
  logic               busy2, valid2, reject2;
  logic [3:0]         digit2;
  logic [7:0]         seven_seg2;

  int n_checks = 0;
  int n_err    = 0;

  logic signed [15:0] cur_vals [16];

  localparam logic [7:0] SEG_TBL [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
    8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  ann_output_classifier #(.NUM_OUTPUTS(16), .DATA_W(16), .THRESHOLD(16'sh0000)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .node_vals(node_vals),
    .busy(busy), .valid(valid), .digit(digit), .reject(reject), .seven_seg(seven_seg));

  ann_output_classifier #(.NUM_OUTPUTS(16), .DATA_W(16), .THRESHOLD(-16'sd10)) dut_t (
    .clk(clk), .n_rst(n_rst), .start(start), .node_vals(node_vals),
    .busy(busy2), .valid(valid2), .digit(digit2), .reject(reject2), .seven_seg(seven_seg2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: find the maximum value, then the first index holding it.
  task automatic model(input logic signed [15:0] thr, output logic [3:0] d,
                       output logic r, output logic [7:0] s);
    logic signed [15:0] mx;
    mx = cur_vals[0];
    foreach (cur_vals[i]) if (cur_vals[i] > mx) mx = cur_vals[i];
    d = 4'd0;
    for (int i = 15; i >= 0; i--) if (cur_vals[i] == mx) d = 4'(i);
    r = (mx < thr);
    s = r ? 8'h40 : SEG_TBL[d];
  endtask

  // Launch one classification of cur_vals; optionally re-pulse start mid-scan
  // (with scrambled inputs) and/or during the valid cycle.
  task automatic run_and_check(input string tag, input int restart_at, input bit start_in_valid);
    logic [3:0] ed, ed2;
    logic       er, er2;
    logic [7:0] es, es2;
    int lat, pulses;
    model(16'sd0,   ed,  er,  es);
    model(-16'sd10, ed2, er2, es2);
    foreach (cur_vals[i]) node_vals[i] = cur_vals[i];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    pulses = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          if (start_in_valid) start = 1'b1;
        end
      end
      if (k == restart_at) begin
        foreach (node_vals[i]) node_vals[i] = 16'sd1000;
        node_vals[14] = 16'sd32000;
        start = 1'b1;
      end
      if (k == 1)  check({tag, " busy_k1"}, {31'd0, busy}, 32'd1);
      if (k == 16) check({tag, " busy_k16"}, {31'd0, busy}, 32'd1);
      if (lat > 0 && k == lat) check({tag, " valid2_sync"}, {31'd0, valid2}, 32'd1);
      if (lat > 0 && k == lat + 1) begin
        check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, " valid_after"}, {31'd0, valid}, 32'd0);
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'd17);
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " digit"}, {28'd0, digit}, {28'd0, ed});
    check({tag, " reject"}, {31'd0, reject}, {31'd0, er});
    check({tag, " seg"}, {24'd0, seven_seg}, {24'd0, es});
    check({tag, " digit_t"}, {28'd0, digit2}, {28'd0, ed2});
    check({tag, " reject_t"}, {31'd0, reject2}, {31'd0, er2});
    check({tag, " seg_t"}, {24'd0, seven_seg2}, {24'd0, es2});
  endtask

  initial begin
    int seen;
    n_rst = 1'b1;
    start = 1'b0;
    foreach (node_vals[i]) node_vals[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst valid", {31'd0, valid}, 32'd0);
    check("rst digit", {28'd0, digit}, 32'd0);
    check("rst reject", {31'd0, reject}, 32'd0);
    check("rst seg", {24'd0, seven_seg}, 32'd0);

    foreach (cur_vals[i]) cur_vals[i] = 16'(i * 10);
    cur_vals[7] = 16'sd500;
    run_and_check("node7", 0, 1'b0);
    check("node7 seg const", {24'd0, seven_seg}, 32'h07);

    foreach (cur_vals[i]) cur_vals[i] = 16'sd100;
    run_and_check("tie", 0, 1'b0);

    foreach (cur_vals[i]) cur_vals[i] = 16'sd0;
    cur_vals[3] = 16'sd900;
    cur_vals[12] = 16'sd900;
    run_and_check("tie2", 0, 1'b0);

    foreach (cur_vals[i]) cur_vals[i] = -16'sd50;
    cur_vals[11] = -16'sd5;
    run_and_check("neg", 0, 1'b0);
    check("neg seg const", {24'd0, seven_seg}, 32'h40);
    check("neg seg_t const", {24'd0, seven_seg2}, 32'h7C);

    foreach (cur_vals[i]) cur_vals[i] = 16'sh8000;
    run_and_check("minval", 0, 1'b0);

    foreach (cur_vals[i]) cur_vals[i] = 16'(i * 10);
    cur_vals[7] = 16'sd500;
    run_and_check("restart", 5, 1'b1);

    // Reset part-way through a scan.
    foreach (cur_vals[i]) cur_vals[i] = 16'(i);
    foreach (node_vals[i]) node_vals[i] = cur_vals[i];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst digit", {28'd0, digit}, 32'd0);
    check("midrst reject", {31'd0, reject}, 32'd0);
    check("midrst seg", {24'd0, seven_seg}, 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check("midrst novalid", 32'(seen), 32'd0);
    run_and_check("postrst", 0, 1'b0);
    check("postrst seg const", {24'd0, seven_seg}, 32'h71);

    for (int n = 0; n < 20; n++) begin
      foreach (cur_vals[i]) begin
        if (n % 2 == 0) cur_vals[i] = 16'($urandom_range(0, 6)) - 16'sd3;
        else            cur_vals[i] = 16'($urandom);
      end
      run_and_check($sformatf("rand%0d", n), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
